// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: hazard codes,
// PC source encodings and the FSM state type.
package pipe_ctrl_pkg;

  localparam logic [2:0] HZ_NONE     = 3'b000;
  localparam logic [2:0] HZ_LOAD_BLT = 3'b001;
  localparam logic [2:0] HZ_BGT      = 3'b010;
  localparam logic [2:0] HZ_BEQ      = 3'b011;
  localparam logic [2:0] HZ_JUMP     = 3'b100;
  localparam logic [2:0] HZ_HALT     = 3'b101;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_LSTALL = 2'b01,
    ST_REDIR  = 2'b10,
    ST_HALT   = 2'b11
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, hold once the maximum is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: turns hazard codes into PC / IF-ID / ID-EX
// control, with registered outputs and saturating event counters.
//
// state  | meaning
// RUN    | normal fetch, hazard code sampled every edge
// LSTALL | one-cycle load-use stall, PC and IF/ID frozen, bubble into ID/EX
// REDIR  | one-cycle redirect to branch/jump target, IF/ID flushed
// HALT   | processor halted until resume
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int HAZARD_WIDTH = 3,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [HAZARD_WIDTH-1:0] hazard,
  input  logic                    if_write,
  input  logic                    resume,
  output logic                    pc_en,
  output logic [1:0]              pc_sel,
  output logic                    ifid_en,
  output logic                    ifid_flush,
  output logic                    idex_bubble,
  output logic                    halted,
  output logic                    hazard_err,
  output logic [COUNT_WIDTH-1:0]  stall_cnt,
  output logic [COUNT_WIDTH-1:0]  flush_cnt
);

  state_t     state, state_nxt;
  logic [1:0] sel_nxt;
  logic       err_set;
  logic       pc_en_nxt, ifid_en_nxt, ifid_flush_nxt, idex_bubble_nxt, halted_nxt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Next-state decode; hazard is only looked at in RUN, resume only in HALT.
  always_comb begin
    state_nxt = state;
    sel_nxt   = PC_SEQ;
    err_set   = 1'b0;
    case (state)
      ST_RUN: begin
        case (hazard)
          HAZARD_WIDTH'(HZ_NONE): ;
          HAZARD_WIDTH'(HZ_LOAD_BLT): begin
            if (if_write) begin
              state_nxt = ST_LSTALL;
            end else begin
              state_nxt = ST_REDIR;
              sel_nxt   = PC_BRANCH;
            end
          end
          HAZARD_WIDTH'(HZ_BGT), HAZARD_WIDTH'(HZ_BEQ): begin
            state_nxt = ST_REDIR;
            sel_nxt   = PC_BRANCH;
          end
          HAZARD_WIDTH'(HZ_JUMP): begin
            state_nxt = ST_REDIR;
            sel_nxt   = PC_JUMP;
          end
          HAZARD_WIDTH'(HZ_HALT): state_nxt = ST_HALT;
          default: err_set = 1'b1;
        endcase
      end
      ST_LSTALL: state_nxt = ST_RUN;
      ST_REDIR:  state_nxt = ST_RUN;
      ST_HALT:   if (resume) state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // Output decode from the upcoming state so outputs can be registered
  // alongside the state and line up with it.
  always_comb begin
    pc_en_nxt       = 1'b1;
    ifid_en_nxt     = 1'b1;
    ifid_flush_nxt  = 1'b0;
    idex_bubble_nxt = 1'b0;
    halted_nxt      = 1'b0;
    case (state_nxt)
      ST_LSTALL: begin
        pc_en_nxt       = 1'b0;
        ifid_en_nxt     = 1'b0;
        idex_bubble_nxt = 1'b1;
      end
      ST_REDIR: begin
        ifid_flush_nxt  = 1'b1;
        idex_bubble_nxt = 1'b1;
      end
      ST_HALT: begin
        pc_en_nxt       = 1'b0;
        ifid_en_nxt     = 1'b0;
        idex_bubble_nxt = 1'b1;
        halted_nxt      = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs; pc_sel carries the redirect target chosen at entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_en       <= 1'b1;
      pc_sel      <= PC_SEQ;
      ifid_en     <= 1'b1;
      ifid_flush  <= 1'b0;
      idex_bubble <= 1'b0;
      halted      <= 1'b0;
    end else begin
      pc_en       <= pc_en_nxt;
      pc_sel      <= (state_nxt == ST_REDIR) ? sel_nxt : PC_SEQ;
      ifid_en     <= ifid_en_nxt;
      ifid_flush  <= ifid_flush_nxt;
      idex_bubble <= idex_bubble_nxt;
      halted      <= halted_nxt;
    end
  end

  // Sticky reserved-code flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          hazard_err <= 1'b0;
    else if (err_set) hazard_err <= 1'b1;
  end

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (state_nxt == ST_LSTALL),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (state_nxt == ST_REDIR),
    .count (flush_cnt)
  );

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameters SHALL be: HAZARD_WIDTH, default 3, hazard code width; COUNT_WIDTH, default 16, event counter width.
REQ-002 Ports SHALL be, clock and reset first:
  clk  input  1  single clock, rising edge.
  rst  input  1  reset, asynchronous and active-high.
  hazard  input  HAZARD_WIDTH  hazard code from the hazard detection unit.
  if_write  input  1  qualifier from the hazard detection unit; distinguishes load-use from branch-less-than on code 001.
  resume  input  1  single-cycle pulse that releases HALT.
  pc_en  output  1  PC register write enable.
  pc_sel  output  2  PC source: 00 sequential, 01 branch target, 10 jump target, 11 reserved (never driven).
  ifid_en  output  1  IF/ID register write enable.
  ifid_flush  output  1  clear IF/ID to NOP.
  idex_bubble  output  1  insert NOP into ID/EX.
  halted  output  1  processor halted.
  hazard_err  output  1  sticky flag, reserved code seen.
  stall_cnt  output  COUNT_WIDTH  load-use stall cycles.
  flush_cnt  output  COUNT_WIDTH  redirect (flush) events.

Function
REQ-003 The block SHALL implement a four-state FSM: RUN, LSTALL, REDIR, HALT.
REQ-004 In RUN, the block SHALL sample hazard and if_write at each rising edge and decode them as follows: 000 none; 001 with if_write=1 load-use; 001 with if_write=0 branch; 010 and 011 branch; 100 jump; 101 halt; 110 and 111 reserved.
REQ-005 The RUN transitions SHALL be: load-use -> LSTALL; branch or jump -> REDIR; halt -> HALT; none or reserved -> RUN.
REQ-006 A reserved code SHALL set hazard_err on the next edge, and hazard_err SHALL remain set until reset.
REQ-007 Outputs SHALL be registered Moore outputs, so every response appears exactly one cycle after the sampling edge.
REQ-008 RUN outputs SHALL be: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, pc_sel=00, halted=0.
REQ-009 LSTALL SHALL last exactly one cycle with pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0, pc_sel=00, and SHALL then return unconditionally to RUN.
REQ-010 REDIR SHALL last exactly one cycle with pc_en=1, pc_sel=01 for a branch or 10 for a jump (latched at entry), ifid_en=1, ifid_flush=1, idex_bubble=1, and SHALL then return to RUN.
REQ-011 HALT SHALL drive pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0, pc_sel=00, halted=1, and SHALL remain in HALT until resume=1 is sampled, then go to RUN.
REQ-012 The hazard input SHALL be ignored in LSTALL, REDIR and HALT; a hazard held across these states SHALL be re-evaluated only once RUN is re-entered.
REQ-013 resume SHALL be ignored outside HALT.
REQ-014 If resume and a halt code are sampled on the same edge while in HALT, the block SHALL go to RUN and then re-enter HALT on the next edge if the halt code persists.
REQ-015 stall_cnt SHALL increment by 1 on every cycle spent in LSTALL and SHALL saturate at 2^COUNT_WIDTH-1 without wrapping.
REQ-016 flush_cnt SHALL increment by 1 on every entry into REDIR and SHALL saturate at 2^COUNT_WIDTH-1 without wrapping.
REQ-017 Back-to-back hazards SHALL each be serviced in full: for example, load-use followed by branch gives RUN, LSTALL, RUN (sample), REDIR.

Reset
REQ-018 While rst=1, the block SHALL hold state RUN asynchronously with pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, pc_sel=00, halted=0, hazard_err=0, stall_cnt=0, flush_cnt=0.
REQ-019 Reset asserted in any state, including mid-LSTALL, mid-REDIR or HALT, SHALL abort that state with no residual stall or flush after release.
REQ-020 The first hazard sample after reset SHALL occur on the first rising edge with rst=0.

Structure
REQ-021 The package pipe_ctrl_pkg SHALL hold the hazard code constants (NONE, LOAD_BLT, BGT, BEQ, JUMP, HALT), the PC_SEL encodings, and the FSM state enum.
REQ-022 A sub-module sat_counter (parameter WIDTH, inputs clk, rst, inc; output count) SHALL be instantiated twice, once for stall_cnt and once for flush_cnt.

Verification
REQ-023 Release reset, then drive hazard=001 with if_write=1 for one cycle -> one cycle of pc_en=0, ifid_en=0, idex_bubble=1, then RUN outputs; stall_cnt=1.
REQ-024 Drive hazard=100 for one cycle -> one cycle of pc_sel=10, ifid_flush=1, idex_bubble=1; flush_cnt=1. Repeat with hazard=001 and if_write=0 -> pc_sel=01; flush_cnt=2.
REQ-025 Drive hazard=101, then pulse resume after 5 cycles -> halted=1 and pc_en=0 for 5 cycles, then RUN outputs. Drive halt and resume together -> HALT is re-entered.
REQ-026 Drive hazard=111 once -> hazard_err=1 with no stall or flush, and hazard_err stays 1 until rst.
REQ-027 Set COUNT_WIDTH=2 and drive 5 load-use stalls -> stall_cnt saturates at 3.
REQ-028 Assert rst mid-REDIR and mid-HALT -> all outputs take reset values immediately, without waiting for a clock edge.
